psram_qpi_ctrl: RTL and testbench
=================================

Name: psram_qpi_ctrl

Overview:
Parametrised quad-SPI PSRAM controller driving NUM_CHIPS chips in lock-step on a shared CS/SCLK, chip k holding nibble k of every word. After power-up it waits INIT_DELAY_CYCLES, issues reset-enable/reset, then switches every chip to QPI mode (0x35). It then serves CPU/VIC-side burst reads and writes of 1..MAX_BURST words. Read data streams out with a per-word valid strobe.

Parameters:
NUM_CHIPS, 2, number of x4 PSRAM chips; WORD_W = 4*NUM_CHIPS
INIT_DELAY_CYCLES, 7500, clk cycles from reset release before the first command (>=150 us at target clk)
MAX_BURST, 8, max words per transaction
BANK_W, 7, bank field width; address = {zero-pad, bank, addrBus} to 24 bits
WAIT_SCLK, 6, read latency in sclk cycles between address and first data (fast read 0xEB)
CS_HIGH_CYCLES, 2, min clk cycles CS stays high between transactions

Ports:
clk  in  1  system clock (memory clock domain)
reset  in  1  asynchronous, active-low reset
CE  in  1  request strobe, sampled when busy=0
write  in  1  1=write burst, 0=read burst
bank  in  BANK_W  upper address bits
addrBus  in  16  lower address bits
numberOfWords  in  clog2(MAX_BURST+1)  burst length
dataToWrite  in  MAX_BURST*WORD_W  write words, word 0 in LSBs
dataRead  out  WORD_W  last read word
dataValid  out  1  one-clk pulse per read word
busy  out  1  high during init and any transaction
initDone  out  1  high once QPI enabled, stays high
io_psram_data  inout  WORD_W  chip k uses bits [4k+3:4k]; bit 4k = SI, 4k+1 = SO in SPI mode
o_psram_cs  out  1  active-low chip select, shared
o_psram_sclk  out  1  serial clock = clk/2, shared

Behaviour:
- Reset (async assert): cs=1, sclk=0, io all Z, busy=1, initDone=0, dataValid=0, dataRead=0, delay counter=INIT_DELAY_CYCLES, state=INIT_DELAY. Reset mid-transaction aborts immediately, CS high same edge, full init re-run.
- SCLK: phase 0 sclk low, phase 1 sclk high. Controller changes io/cs only on edges entering phase 0; samples read io on the edge ending phase 1. sclk idles low with cs high.
- States: INIT_DELAY -> RST_EN -> CS_GAP -> RST -> CS_GAP -> EN_QPI -> CS_GAP -> IDLE -> CMD -> ADDR -> (read: WAIT) -> DATA -> CS_GAP -> IDLE.
- INIT_DELAY: counts down to 0, cs=1.
- RST_EN (0x66), RST (0x99), EN_QPI (0x35): SPI mode, MSB first, 8 sclk (16 clk); bit on every chip's SI (io[4k]); SO and io[4k+2], io[4k+3] held Z.
- After EN_QPI: initDone=1, busy=0 on same edge IDLE entered.
- IDLE: CE=1 and numberOfWords!=0 latches all inputs, busy=1 next edge. numberOfWords=0 ignored, busy stays 0. numberOfWords>MAX_BURST clamped to MAX_BURST. CE while busy=1 ignored.
- CMD: 2 sclk, nibbles of 0x38 (write) or 0xEB (read), high nibble first, same nibble on every chip.
- ADDR: 6 sclk, 24-bit address high nibble first, same on every chip.
- WAIT (read only): WAIT_SCLK sclk, io Z.
- DATA write: word i driven, chip k gets dataToWrite[i*WORD_W+4k+3 : i*WORD_W+4k], one word per sclk.
- DATA read: io Z; word assembled from all chips, dataRead updated and dataValid pulsed on sampling edge, one pulse per word, in order.
- CS_GAP: cs=1, io Z, CS_HIGH_CYCLES clk; busy falls entering IDLE.
- Latency: write of N words = 2*(8+N) clk cs low; read = 2*(8+WAIT_SCLK+N) clk cs low; first dataValid 2*(8+WAIT_SCLK)+2 clk after cs falls.
- Address does not wrap inside controller; chip page wrap is the requester's concern.

Test Plan:
- Reset low 10 clk, release -> cs=1, busy=1, io Z for 7500 clk; then cs=0, io[0]/io[4] show 0,1,1,0,0,1,1,0 (0x66) one bit per sclk, io[1]/io[5] Z.
- Init sequence -> 0x66, 0x99, 0x35 with cs high >=2 clk between; initDone=1, busy=0 after 0x35.
- Write bank=0x01, addr=0x1234, N=2, data words 0xA5,0x3C -> nibbles 3,8 / 0,1,1,2,3,4 / then io[3:0]=5,io[7:4]=A, then C,3; cs low exactly 20 clk.
- Read N=3 with chip model returning 0x11,0x22,0x33 -> 0xEB, addr, 6 wait sclk, three dataValid pulses 2 clk apart with dataRead 0x11,0x22,0x33.
- CE with numberOfWords=0 -> no cs activity, busy stays 0; N=15 -> exactly 8 words transferred.
- Reset asserted during DATA of a read -> cs=1 and io Z immediately, busy=1, initDone=0, full init repeats.

Source files
------------

// File: rtl/psram_qpi_ctrl.sv
// Quad-SPI PSRAM controller: NUM_CHIPS x4 chips run in lock-step on a shared CS/SCLK,
// chip k carrying nibble k of every word. Runs reset + QPI-enable after power-up,
// then serves burst reads (0xEB) and writes (0x38).
module psram_qpi_ctrl #(
    parameter int unsigned NUM_CHIPS         = 2,
    parameter int unsigned INIT_DELAY_CYCLES = 7500,
    parameter int unsigned MAX_BURST         = 8,
    parameter int unsigned BANK_W            = 7,
    parameter int unsigned WAIT_SCLK         = 6,
    parameter int unsigned CS_HIGH_CYCLES    = 2,
    localparam int unsigned WORD_W           = 4 * NUM_CHIPS,
    localparam int unsigned NUM_W            = $clog2(MAX_BURST + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        CE,
    input  logic                        write,
    input  logic [BANK_W-1:0]           bank,
    input  logic [15:0]                 addrBus,
    input  logic [NUM_W-1:0]            numberOfWords,
    input  logic [MAX_BURST*WORD_W-1:0] dataToWrite,
    output logic [WORD_W-1:0]           dataRead,
    output logic                        dataValid,
    output logic                        busy,
    output logic                        initDone,
    inout  wire  [WORD_W-1:0]           io_psram_data,
    output logic                        o_psram_cs,
    output logic                        o_psram_sclk
);

    localparam int unsigned DLY_W = $clog2(INIT_DELAY_CYCLES + 1);
    localparam logic [DLY_W-1:0] InitDly = DLY_W'(INIT_DELAY_CYCLES);
    localparam logic [DLY_W-1:0] GapDly = DLY_W'(CS_HIGH_CYCLES - 1);
    localparam logic [7:0] WaitLast = 8'(WAIT_SCLK - 1);

    typedef enum logic [3:0] {
        StInitDelay, StRstEn, StRst, StEnQpi, StCsGap, StIdle, StCmd, StAddr, StWait, StData
    } stateT;

    stateT stateQ, stateD, gapNextQ, gapNextD, afterShift;
    logic [DLY_W-1:0] delayQ, delayD;
    logic phaseQ, phaseD;
    logic [7:0] cntQ, cntD, lastCnt;
    logic shifting;
    logic writeQ, writeD;
    logic [23:0] addrQ, addrD;
    logic [NUM_W-1:0] numQ, numD;
    logic [MAX_BURST*WORD_W-1:0] dataQ, dataD;
    logic busyQ, busyD, initDoneQ, initDoneD, validQ, validD;
    logic [WORD_W-1:0] readQ, readD;
    logic csQ, csD, sclkQ, sclkD;
    logic [WORD_W-1:0] ioOutQ, ioOutD, ioOeQ, ioOeD;
    logic [7:0] spiByte, spiShift, cmdByte;
    logic [23:0] addrShift;
    logic [MAX_BURST*WORD_W-1:0] wordShift;
    logic [3:0] nibble;
    logic quad;

    // Sequencing: init countdown, CS gaps, request capture and the per-sclk shift engine.
    always_comb begin
        stateD     = stateQ;
        gapNextD   = gapNextQ;
        delayD     = delayQ;
        phaseD     = phaseQ;
        cntD       = cntQ;
        writeD     = writeQ;
        addrD      = addrQ;
        numD       = numQ;
        dataD      = dataQ;
        busyD      = busyQ;
        initDoneD  = initDoneQ;
        readD      = readQ;
        validD     = 1'b0;
        shifting   = 1'b0;
        lastCnt    = 8'd0;
        afterShift = StCsGap;
        unique case (stateQ)
            StInitDelay: begin
                if (delayQ == '0) begin
                    stateD = StRstEn;
                    phaseD = 1'b0;
                    cntD   = 8'd0;
                end else begin
                    delayD = delayQ - 1'b1;
                end
            end
            StRstEn: begin
                shifting = 1'b1;
                lastCnt  = 8'd7;
                gapNextD = StRst;
            end
            StRst: begin
                shifting = 1'b1;
                lastCnt  = 8'd7;
                gapNextD = StEnQpi;
            end
            StEnQpi: begin
                shifting = 1'b1;
                lastCnt  = 8'd7;
                gapNextD = StIdle;
            end
            StCsGap: begin
                if (delayQ == '0) begin
                    stateD = gapNextQ;
                    phaseD = 1'b0;
                    cntD   = 8'd0;
                    if (gapNextQ == StIdle) begin
                        busyD     = 1'b0;
                        initDoneD = 1'b1;
                    end
                end else begin
                    delayD = delayQ - 1'b1;
                end
            end
            StIdle: begin
                if (CE && numberOfWords != '0) begin
                    stateD = StCmd;
                    busyD  = 1'b1;
                    phaseD = 1'b0;
                    cntD   = 8'd0;
                    writeD = write;
                    addrD  = 24'({bank, addrBus});
                    numD   = (numberOfWords > NUM_W'(MAX_BURST)) ? NUM_W'(MAX_BURST)
                                                                 : numberOfWords;
                    dataD  = dataToWrite;
                end
            end
            StCmd: begin
                shifting   = 1'b1;
                lastCnt    = 8'd1;
                afterShift = StAddr;
            end
            StAddr: begin
                shifting   = 1'b1;
                lastCnt    = 8'd5;
                afterShift = writeQ ? StData : StWait;
            end
            StWait: begin
                shifting   = 1'b1;
                lastCnt    = WaitLast;
                afterShift = StData;
            end
            StData: begin
                shifting   = 1'b1;
                lastCnt    = 8'(numQ) - 8'd1;
                afterShift = StCsGap;
                gapNextD   = StIdle;
            end
            default: stateD = StInitDelay;
        endcase
        // Phase 1 -> phase 0 edge ends an sclk: sample reads, advance the beat counter.
        if (shifting) begin
            if (!phaseQ) begin
                phaseD = 1'b1;
            end else begin
                phaseD = 1'b0;
                if (stateQ == StData && !writeQ) begin
                    validD = 1'b1;
                    readD  = io_psram_data;
                end
                if (cntQ == lastCnt) begin
                    stateD = afterShift;
                    cntD   = 8'd0;
                    if (afterShift == StCsGap) begin
                        delayD = GapDly;
                    end
                end else begin
                    cntD = cntQ + 8'd1;
                end
            end
        end
    end

    // Pin decode from the next state so CS/SCLK/IO leave the flops glitch-free.
    always_comb begin
        csD       = 1'b1;
        sclkD     = 1'b0;
        ioOutD    = '0;
        ioOeD     = '0;
        quad      = 1'b0;
        nibble    = 4'h0;
        spiByte   = 8'h00;
        spiShift  = 8'h00;
        cmdByte   = writeD ? 8'h38 : 8'hEB;
        addrShift = addrD << {cntD[2:0], 2'b00};
        wordShift = dataD >> (int'(cntD) * WORD_W);
        unique case (stateD)
            StRstEn, StRst, StEnQpi: begin
                csD      = 1'b0;
                sclkD    = phaseD;
                spiByte  = (stateD == StRstEn) ? 8'h66 : (stateD == StRst) ? 8'h99 : 8'h35;
                spiShift = spiByte << cntD[2:0];
                for (int k = 0; k < NUM_CHIPS; k++) begin
                    ioOeD[4*k]  = 1'b1;
                    ioOutD[4*k] = spiShift[7];
                end
            end
            StCmd: begin
                csD    = 1'b0;
                sclkD  = phaseD;
                quad   = 1'b1;
                nibble = cntD[0] ? cmdByte[3:0] : cmdByte[7:4];
            end
            StAddr: begin
                csD    = 1'b0;
                sclkD  = phaseD;
                quad   = 1'b1;
                nibble = addrShift[23:20];
            end
            StWait: begin
                csD   = 1'b0;
                sclkD = phaseD;
            end
            StData: begin
                csD   = 1'b0;
                sclkD = phaseD;
                if (writeD) begin
                    ioOeD  = '1;
                    ioOutD = wordShift[WORD_W-1:0];
                end
            end
            default: ;
        endcase
        if (quad) begin
            ioOeD  = '1;
            ioOutD = {NUM_CHIPS{nibble}};
        end
    end

    // State and pin registers; reset aborts any transfer and restarts the init sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= StInitDelay;
            gapNextQ  <= StRst;
            delayQ    <= InitDly;
            phaseQ    <= 1'b0;
            cntQ      <= 8'd0;
            writeQ    <= 1'b0;
            addrQ     <= '0;
            numQ      <= '0;
            dataQ     <= '0;
            busyQ     <= 1'b1;
            initDoneQ <= 1'b0;
            validQ    <= 1'b0;
            readQ     <= '0;
            csQ       <= 1'b1;
            sclkQ     <= 1'b0;
            ioOutQ    <= '0;
            ioOeQ     <= '0;
        end else begin
            stateQ    <= stateD;
            gapNextQ  <= gapNextD;
            delayQ    <= delayD;
            phaseQ    <= phaseD;
            cntQ      <= cntD;
            writeQ    <= writeD;
            addrQ     <= addrD;
            numQ      <= numD;
            dataQ     <= dataD;
            busyQ     <= busyD;
            initDoneQ <= initDoneD;
            validQ    <= validD;
            readQ     <= readD;
            csQ       <= csD;
            sclkQ     <= sclkD;
            ioOutQ    <= ioOutD;
            ioOeQ     <= ioOeD;
        end
    end

    for (genvar i = 0; i < WORD_W; i++) begin : gIo
        assign io_psram_data[i] = ioOeQ[i] ? ioOutQ[i] : 1'bz;
    end

    assign dataRead     = readQ;
    assign dataValid    = validQ;
    assign busy         = busyQ;
    assign initDone     = initDoneQ;
    assign o_psram_cs   = csQ;
    assign o_psram_sclk = sclkQ;

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// Scoreboard bench for psram_qpi_ctrl: expected bus beats, CS-low lengths and read words
// are queued when a request is issued and consumed as the controller produces them.
module tb_psram_qpi_ctrl;

    localparam int unsigned MaxBurst   = 8;
    localparam int unsigned WaitSclk   = 6;
    localparam int unsigned CsHigh     = 2;
    localparam int unsigned InitDelay  = 7500;
    localparam int unsigned FirstValid = 2 * (8 + WaitSclk) + 2;

    typedef struct {
        logic [7:0] val;
        logic [7:0] oe;
        logic       drv;
    } beatT;

    logic        clk = 1'b0;
    logic        reset;
    logic        CE;
    logic        write;
    logic [6:0]  bank;
    logic [15:0] addrBus;
    logic [3:0]  numberOfWords;
    logic [63:0] dataToWrite;
    logic [7:0]  dataRead;
    logic        dataValid;
    logic        busy;
    logic        initDone;
    wire  [7:0]  io;
    logic        cs;
    logic        sclk;
    logic [7:0]  chipOut;
    logic        chipOe;

    beatT        expBeatQ[$];
    logic [7:0]  dataExpQ[$];
    int          expCsLenQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;

    int          cyc = 0, lowCnt = 0, highCnt = 0, csFallCyc = 0, lastValidCyc = 0, validCnt = 0;
    logic        prevCs = 1'b1, havePrev = 1'b0;
    beatT        b;
    logic [7:0]  e8;
    int          eLen;

    psram_qpi_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .CE            (CE),
        .write         (write),
        .bank          (bank),
        .addrBus       (addrBus),
        .numberOfWords (numberOfWords),
        .dataToWrite   (dataToWrite),
        .dataRead      (dataRead),
        .dataValid     (dataValid),
        .busy          (busy),
        .initDone      (initDone),
        .io_psram_data (io),
        .o_psram_cs    (cs),
        .o_psram_sclk  (sclk)
    );

    assign io = chipOe ? chipOut : 8'hzz;

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor and chip model, sampled on the falling clk edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chipOe   = 1'b0;
            lowCnt   = 0;
            highCnt  = 0;
            prevCs   = 1'b1;
            havePrev = 1'b0;
            validCnt = 0;
        end else begin
            if (dataValid) begin
                if (dataExpQ.size() == 0) begin
                    checkVal("validUnexpected", dataExpQ.size(), 1);
                end else begin
                    e8 = dataExpQ.pop_front();
                    checkVal("dataRead", dataRead, e8);
                    if (validCnt == 0) checkVal("firstValidLat", cyc - csFallCyc, FirstValid);
                    else checkVal("validSpacing", cyc - lastValidCyc, 2);
                end
                lastValidCyc = cyc;
                validCnt++;
            end
            if (!cs) begin
                if (prevCs) begin
                    if (havePrev) checkVal("csGap", highCnt >= CsHigh, 1);
                    csFallCyc = cyc;
                    validCnt  = 0;
                end
                lowCnt++;
                if (sclk) begin
                    if (expBeatQ.size() == 0) begin
                        checkVal("beatUnexpected", expBeatQ.size(), 1);
                    end else begin
                        b = expBeatQ.pop_front();
                        checkVal("beatOe", dut.ioOeQ, b.oe);
                        checkVal("beatIo", io & b.oe, b.val & b.oe);
                        chipOut = b.val;
                        chipOe  = b.drv;
                    end
                end
            end else begin
                chipOe = 1'b0;
                if (!prevCs) begin
                    if (expCsLenQ.size() == 0) begin
                        checkVal("csLowUnexpected", expCsLenQ.size(), 1);
                    end else begin
                        eLen = expCsLenQ.pop_front();
                        checkVal("csLowLen", lowCnt, eLen);
                    end
                    havePrev = 1'b1;
                    highCnt  = 0;
                end
                lowCnt = 0;
                highCnt++;
            end
            prevCs = cs;
        end
    end

    task automatic pushSpi(input logic [7:0] cmd);
        for (int i = 7; i >= 0; i--) begin
            expBeatQ.push_back('{val: cmd[i] ? 8'h11 : 8'h00, oe: 8'h11, drv: 1'b0});
        end
        expCsLenQ.push_back(16);
    endtask

    task automatic pushTxn(input logic wr, input logic [6:0] bk, input logic [15:0] ad,
                           input logic [3:0] n, input logic [63:0] data);
        logic [7:0]  cmd;
        logic [23:0] a;
        logic [7:0]  w;
        int          m;
        cmd = wr ? 8'h38 : 8'hEB;
        expBeatQ.push_back('{val: {2{cmd[7:4]}}, oe: 8'hFF, drv: 1'b0});
        expBeatQ.push_back('{val: {2{cmd[3:0]}}, oe: 8'hFF, drv: 1'b0});
        a = {1'b0, bk, ad};
        for (int i = 0; i < 6; i++) begin
            expBeatQ.push_back('{val: {2{a[23:20]}}, oe: 8'hFF, drv: 1'b0});
            a = a << 4;
        end
        if (!wr) begin
            for (int i = 0; i < WaitSclk; i++) expBeatQ.push_back('{val: 8'h00, oe: 8'h00, drv: 1'b0});
        end
        m = (n > 4'(MaxBurst)) ? MaxBurst : int'(n);
        for (int i = 0; i < m; i++) begin
            w = data[i*8 +: 8];
            if (wr) begin
                expBeatQ.push_back('{val: w, oe: 8'hFF, drv: 1'b0});
            end else begin
                expBeatQ.push_back('{val: w, oe: 8'h00, drv: 1'b1});
                dataExpQ.push_back(w);
            end
        end
        expCsLenQ.push_back(2 * (8 + (wr ? 0 : WaitSclk) + m));
    endtask

    task automatic waitIdle(input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        checkVal("busyDone", busy, 0);
    endtask

    // Issue one request; with holdCe the strobe stays high (and is ignored) while busy.
    task automatic doTxn(input logic wr, input logic [6:0] bk, input logic [15:0] ad,
                         input logic [3:0] n, input logic [63:0] data, input logic holdCe);
        pushTxn(wr, bk, ad, n, data);
        @(negedge clk);
        #1;
        CE            = 1'b1;
        write         = wr;
        bank          = bk;
        addrBus       = ad;
        numberOfWords = n;
        dataToWrite   = data;
        @(negedge clk);
        #1;
        CE = holdCe;
        checkVal("busyTake", busy, 1);
        write         = ~wr;
        addrBus       = 16'($urandom);
        numberOfWords = 4'd5;
        dataToWrite   = {$urandom, $urandom};
        waitIdle(300);
        #1;
        CE = 1'b0;
    endtask

    task automatic doInit();
        int n;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checkVal("rstCs", cs, 1);
        checkVal("rstSclk", sclk, 0);
        checkVal("rstBusy", busy, 1);
        checkVal("rstInitDone", initDone, 0);
        checkVal("rstValid", dataValid, 0);
        checkVal("rstDataRead", dataRead, 0);
        checkVal("rstIoZ", dut.ioOeQ, 0);
        expBeatQ.delete();
        dataExpQ.delete();
        expCsLenQ.delete();
        pushSpi(8'h66);
        pushSpi(8'h99);
        pushSpi(8'h35);
        reset = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!cs || n >= InitDelay + 500) break;
            n++;
        end
        checkVal("initDelay", n, InitDelay);
        checkVal("initBusy", busy, 1);
        n = 0;
        while (!initDone && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkVal("initDone", initDone, 1);
        checkVal("idleBusy", busy, 0);
    endtask

    initial begin
        int k;
        logic [63:0] d;
        reset         = 1'b0;
        CE            = 1'b0;
        write         = 1'b0;
        bank          = '0;
        addrBus       = '0;
        numberOfWords = '0;
        dataToWrite   = '0;
        chipOe        = 1'b0;
        chipOut       = '0;

        doInit();
        doTxn(1'b1, 7'h01, 16'h1234, 4'd2, 64'h3CA5, 1'b0);
        doTxn(1'b0, 7'h02, 16'h0100, 4'd3, 64'h332211, 1'b1);

        // Zero-length request must leave the bus and busy untouched.
        @(negedge clk);
        #1;
        CE            = 1'b1;
        write         = 1'b1;
        numberOfWords = 4'd0;
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) k++;
            if (!cs) k++;
        end
        #1;
        CE = 1'b0;
        checkVal("zeroLenIdle", k, 0);

        doTxn(1'b1, 7'h55, 16'hBEEF, 4'd15, {$urandom, $urandom}, 1'b0);
        doTxn(1'b0, 7'h7F, 16'hFFFF, 4'd15, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 4; i++) begin
            doTxn(1'($urandom), 7'($urandom), 16'($urandom), 4'($urandom_range(1, 8)),
                  {$urandom, $urandom}, 1'b0);
        end

        // Reset in the middle of a read's data phase.
        d = {$urandom, $urandom};
        pushTxn(1'b0, 7'h03, 16'h4000, 4'd8, d);
        @(negedge clk);
        #1;
        CE            = 1'b1;
        write         = 1'b0;
        bank          = 7'h03;
        addrBus       = 16'h4000;
        numberOfWords = 4'd8;
        @(negedge clk);
        #1;
        CE = 1'b0;
        k = 0;
        while (dataExpQ.size() > 5 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkVal("abortPoint", dataExpQ.size(), 5);
        #1;
        reset = 1'b0;
        #1;
        checkVal("abortCs", cs, 1);
        checkVal("abortIoZ", dut.ioOeQ, 0);
        checkVal("abortBusy", busy, 1);
        checkVal("abortInitDone", initDone, 0);
        doInit();
        doTxn(1'b1, 7'h10, 16'h0008, 4'd4, {$urandom, $urandom}, 1'b0);
        doTxn(1'b0, 7'h10, 16'h0008, 4'd4, {$urandom, $urandom}, 1'b0);

        repeat (10) @(negedge clk);
        checkVal("beatsLeft", expBeatQ.size(), 0);
        checkVal("wordsLeft", dataExpQ.size(), 0);
        checkVal("csLenLeft", expCsLenQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
